hack_run_checker: RTL
=====================

Name: hack_run_checker

Overview:
Synthesizable self-test sequencer that sits beside hack_cpu on the data bus. It holds the CPU in reset for a programmable number of cycles, releases it, and snoops the addressM/outM/writeM bus. It checks up to NUM_CHECKS watched RAM addresses against expected values, then reports pass/fail. It is the in-hardware form of the integration check, usable both in simulation and on the Basys3 board (status on LEDs).

Parameters:
NUM_CHECKS, 4, number of watch channels (>=1)
RESET_CYCLES, 2, clocks cpu_reset is held high per run (>=1)
TIMEOUT_CYCLES, 20, max clocks in RUN before verdict (>=1)
CNT_W, 16, width of the write counter
AUTO_START, 1, 1 = start a run automatically when reset is released
EARLY_EXIT, 1, 1 = finish as soon as all enabled channels match

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
addressM  in  15  CPU data address
outM  in  16  CPU write data
writeM  in  1  CPU write strobe
watch_en  in  NUM_CHECKS  per-channel enable; bit i enables channel i
watch_addr  in  NUM_CHECKS*15  channel i address at bits [15i+14:15i]
watch_data  in  NUM_CHECKS*16  channel i expected value at bits [16i+15:16i]
cpu_reset  out  1  registered reset to hack_cpu
busy  out  1  high in HOLD or RUN
done  out  1  high in DONE
pass  out  1  verdict; valid when done
fail  out  1  verdict; valid when done; never high together with pass
match_mask  out  NUM_CHECKS  bit i = channel i seen and last write matched
write_count  out  CNT_W  writeM cycles during RUN, saturating
first_bad_idx  out  max(1,$clog2(NUM_CHECKS))  lowest enabled non-matching channel; 0 if none

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- States: IDLE, HOLD, RUN, DONE. All outputs are registered.
- During reset:
  - state becomes HOLD if AUTO_START=1, else IDLE.
  - cpu_reset=1; done=pass=fail=0; match_mask=0; write_count=0; first_bad_idx=0.
  - Internal seen/match flags and counters are cleared.
- IDLE: cpu_reset=1. A start pulse clears flags, counters and verdict, then moves to HOLD.
- HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES clocks, counted from HOLD entry.
  - Then RUN. cpu_reset is 0 from the first RUN cycle.
  - start is ignored.
- RUN:
  - Each cycle with writeM=1, write_count increments, saturating at 2^CNT_W-1.
  - For each enabled channel i with addressM==watch_addr[i]: seen[i] is set and match[i] is set to (outM==watch_data[i]). The last write wins, so a later mismatching write clears match[i].
  - Several channels may share one address; all of them update in the same cycle.
  - The timer counts RUN cycles. The write in the final (TIMEOUT_CYCLES-th) RUN cycle is still sampled.
  - Early exit: if EARLY_EXIT=1 and watch_en!=0 and every enabled channel is seen&&match, enter DONE on the next clock.
  - Otherwise enter DONE after TIMEOUT_CYCLES RUN cycles.
  - start is ignored.
- DONE entry:
  - pass=1 iff watch_en!=0 and all enabled channels are seen&&match; fail is the complement.
  - first_bad_idx is computed from the flags frozen at entry.
- DONE:
  - cpu_reset stays 0 (CPU keeps running).
  - Monitoring stops; flags, write_count and verdict are frozen.
  - start begins a new run via HOLD with everything cleared.
- match_mask[i] = seen[i] & match[i] & watch_en[i], updated live during RUN.
- watch_* inputs must be stable from start through DONE; they are sampled combinationally.
- Reset asserted mid-run overrides everything and has the reset-state effect on the same clock edge.

Test Plan:
- AUTO_START=1, NUM_CHECKS=1, channel 0 = (100, 0x3039); drive write 100<-0x3039 in RUN cycle 3 -> cpu_reset high for 2 clocks after reset; done one clock after the write; pass=1, match_mask=1, write_count=1.
- Same setup, write 100<-0x3039 then 100<-0x0000 with EARLY_EXIT=0 -> at timeout fail=1, pass=0, match_mask=0, first_bad_idx=0.
- NUM_CHECKS=4, watch_en=4'b1011, channels 0, 1 and 3 written correctly, channel 2 never written -> early exit; pass=1; channel 2 ignored.
- watch_en=4'b1111, channel 2 gets the wrong value -> DONE at TIMEOUT_CYCLES; fail=1, first_bad_idx=2, match_mask=4'b1011.
- watch_en=0 -> no early exit; DONE after TIMEOUT_CYCLES, fail=1.
- In RUN, assert reset for one clock, then (AUTO_START=0) pulse start -> after reset: IDLE, cpu_reset=1, all status 0; start -> HOLD for RESET_CYCLES, then RUN with write_count=0. Also CNT_W=2 with 5 writes -> write_count=3.

Source files
------------

// File: rtl/hack_run_checker.sv
// hack_run_checker: holds hack_cpu in reset, releases it, snoops data-bus writes and reports a pass/fail verdict
module hack_run_checker #(
  parameter int NUM_CHECKS = 4,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int CNT_W = 16,
  parameter bit AUTO_START = 1,
  parameter bit EARLY_EXIT = 1,
  localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1,
  localparam int CW = $clog2((RESET_CYCLES > TIMEOUT_CYCLES ? RESET_CYCLES : TIMEOUT_CYCLES) + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [14:0]              addressM,
  input  logic [15:0]              outM,
  input  logic                     writeM,
  input  logic [NUM_CHECKS-1:0]    watch_en,
  input  logic [NUM_CHECKS*15-1:0] watch_addr,
  input  logic [NUM_CHECKS*16-1:0] watch_data,
  output logic                     cpu_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [NUM_CHECKS-1:0]    match_mask,
  output logic [CNT_W-1:0]         write_count,
  output logic [IW-1:0]            first_bad_idx
);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_CHECKS-1:0] seen, match, seen_n, match_n, bad;
  logic [IW-1:0] bad_idx;
  logic all_ok, clear;
  assign busy = state == HOLD || state == RUN;
  assign done = state == DONE;
  assign cpu_reset = state == IDLE || state == HOLD;
  assign match_mask = seen & match & watch_en;
  assign clear = (state == IDLE || state == DONE) && start;
  // Verdict and early exit look at this cycle's write so DONE follows the final matching write directly.
  always_comb begin
    seen_n = seen;
    match_n = match;
    for (int i = 0; i < NUM_CHECKS; i++)
      if (state == RUN && writeM && watch_en[i] && addressM == watch_addr[15*i +: 15]) begin
        seen_n[i] = 1'b1;
        match_n[i] = outM == watch_data[16*i +: 16];
      end
    bad = watch_en & ~(seen_n & match_n);
    all_ok = |watch_en && ~|bad;
    bad_idx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--)
      if (bad[i]) bad_idx = IW'(i);
    state_n = state;
    case (state)
      IDLE: state_n = start ? HOLD : IDLE;
      HOLD: state_n = cnt == CW'(RESET_CYCLES - 1) ? RUN : HOLD;
      RUN:  state_n = ((EARLY_EXIT && all_ok) || cnt == CW'(TIMEOUT_CYCLES - 1)) ? DONE : RUN;
      DONE: state_n = start ? HOLD : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AUTO_START ? HOLD : IDLE;
      cnt <= '0;
      seen <= '0;
      match <= '0;
      write_count <= '0;
      pass <= 1'b0;
      fail <= 1'b0;
      first_bad_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= (busy && state_n == state) ? cnt + 1'b1 : '0;
      if (clear) begin
        seen <= '0;
        match <= '0;
        write_count <= '0;
        pass <= 1'b0;
        fail <= 1'b0;
        first_bad_idx <= '0;
      end
      if (state == RUN) begin
        seen <= seen_n;
        match <= match_n;
        if (writeM && ~&write_count) write_count <= write_count + 1'b1;
        if (state_n == DONE) begin
          pass <= all_ok;
          fail <= !all_ok;
          first_bad_idx <= bad_idx;
        end
      end
    end
  end
endmodule
